// File: rtl/tl_request_conditioner.sv
// Input conditioning for the traffic light controller: synchronises and debounces the
// car, pedestrian and emergency inputs, latches pedestrian requests, stretches emergency.
module tl_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned EMERG_HOLD      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic car_raw,
    input  logic ped_button_raw,
    input  logic emerg_raw,
    input  logic ped_served,
    output logic sensor_car,
    output logic sensor_pedestrian,
    output logic emergency
);

    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned CH_CAR   = 0;
    localparam int unsigned CH_PED   = 1;
    localparam int unsigned CH_EMERG = 2;
    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LOAD = 8'(EMERG_HOLD);

    typedef enum logic [1:0] {
        PED_IDLE    = 2'b00,
        PED_PENDING = 2'b01,
        PED_SERVING = 2'b10
    } ped_state_t;

    logic [NUM_CH-1:0]       raw;
    logic [NUM_CH-1:0]       sync1;
    logic [NUM_CH-1:0]       sync2;
    logic [NUM_CH-1:0]       deb;
    logic [NUM_CH-1:0]       deb_flip;
    logic [NUM_CH-1:0][7:0]  cnt;
    logic                    deb_ped_q;
    logic                    ped_rise;
    logic                    ped_req;
    ped_state_t              ped_state;
    logic [7:0]              hold_cnt;

    assign raw = {emerg_raw, ped_button_raw, car_raw};

    // A channel flips on the edge its disagreement has lasted DEBOUNCE_CYCLES samples.
    always_comb begin
        deb_flip = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            deb_flip[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (deb_flip[i]) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign ped_rise = deb[CH_PED] & ~deb_ped_q;

    // Request flag is registered alongside the state so the output is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_ped_q <= 1'b0;
            ped_state <= PED_IDLE;
            ped_req   <= 1'b0;
        end else begin
            deb_ped_q <= deb[CH_PED];
            case (ped_state)
                PED_IDLE: begin
                    if (ped_rise) begin
                        ped_state <= PED_PENDING;
                        ped_req   <= 1'b1;
                    end
                end
                PED_PENDING: begin
                    if (ped_served) begin
                        ped_state <= PED_SERVING;
                        ped_req   <= 1'b0;
                    end
                end
                PED_SERVING: begin
                    if (!ped_served) begin
                        ped_state <= PED_IDLE;
                    end
                end
                default: begin
                    ped_state <= PED_IDLE;
                    ped_req   <= 1'b0;
                end
            endcase
        end
    end

    // Hold is loaded on the debounced fall and cancelled on the debounced rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (deb_flip[CH_EMERG]) begin
            hold_cnt <= deb[CH_EMERG] ? HOLD_LOAD : '0;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign sensor_car        = deb[CH_CAR];
    assign sensor_pedestrian = ped_req;
    assign emergency         = deb[CH_EMERG] | (hold_cnt != '0);

endmodule

// File: tb/tb_tl_request_conditioner.sv
// Directed bench for tl_request_conditioner at default parameters (8-cycle debounce, 16-cycle hold).
module tb_tl_request_conditioner;

    logic clk;
    logic rst_n;
    logic car_raw;
    logic ped_button_raw;
    logic emerg_raw;
    logic ped_served;
    logic sensor_car;
    logic sensor_pedestrian;
    logic emergency;

    int checks;
    int errors;

    tl_request_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .EMERG_HOLD(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .car_raw(car_raw),
        .ped_button_raw(ped_button_raw),
        .emerg_raw(emerg_raw),
        .ped_served(ped_served),
        .sensor_car(sensor_car),
        .sensor_pedestrian(sensor_pedestrian),
        .emergency(emergency)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, leaving the bench 1 time unit past the last edge.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({sensor_car, sensor_pedestrian, emergency} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold got %b exp 000", {sensor_car, sensor_pedestrian, emergency});
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
        checks++;
        if ({sensor_car, sensor_pedestrian, emergency} !== 3'b000) begin
            errors++;
            $display("FAIL reset_first_cycle got %b exp 000", {sensor_car, sensor_pedestrian, emergency});
        end
    endtask

    task automatic test_car_latency();
        logic exp;
        for (int n = 1; n <= 20; n++) begin
            car_raw = 1'b1;
            tick(1);
            exp = (n >= 10);
            checks++;
            if (sensor_car !== exp) begin
                errors++;
                $display("FAIL car_rise tick=%0d got %b exp %b", n, sensor_car, exp);
            end
        end
        for (int n = 1; n <= 12; n++) begin
            car_raw = 1'b0;
            tick(1);
            exp = (n <= 9);
            checks++;
            if (sensor_car !== exp) begin
                errors++;
                $display("FAIL car_fall tick=%0d got %b exp %b", n, sensor_car, exp);
            end
        end
        // 7-cycle pulse is one short of the threshold, 8-cycle pulse just passes.
        for (int n = 1; n <= 20; n++) begin
            car_raw = (n <= 7);
            tick(1);
            checks++;
            if (sensor_car !== 1'b0) begin
                errors++;
                $display("FAIL car_pulse7 tick=%0d got %b exp 0", n, sensor_car);
            end
        end
        for (int n = 1; n <= 20; n++) begin
            car_raw = (n <= 8);
            tick(1);
            exp = (n >= 10) && (n <= 17);
            checks++;
            if (sensor_car !== exp) begin
                errors++;
                $display("FAIL car_pulse8 tick=%0d got %b exp %b", n, sensor_car, exp);
            end
        end
    endtask

    task automatic test_ped_bounce();
        logic exp;
        for (int n = 1; n <= 45; n++) begin
            ped_button_raw = (n <= 3) || (n >= 14 && n <= 18) || (n >= 29 && n <= 35);
            tick(1);
            checks++;
            if (sensor_pedestrian !== 1'b0) begin
                errors++;
                $display("FAIL ped_bounce tick=%0d got %b exp 0", n, sensor_pedestrian);
            end
        end
        for (int n = 1; n <= 20; n++) begin
            ped_button_raw = 1'b1;
            tick(1);
            exp = (n >= 11);
            checks++;
            if (sensor_pedestrian !== exp) begin
                errors++;
                $display("FAIL ped_steady tick=%0d got %b exp %b", n, sensor_pedestrian, exp);
            end
        end
        for (int n = 1; n <= 25; n++) begin
            ped_button_raw = 1'b0;
            tick(1);
            checks++;
            if (sensor_pedestrian !== 1'b1) begin
                errors++;
                $display("FAIL ped_latched tick=%0d got %b exp 1", n, sensor_pedestrian);
            end
        end
        ped_served = 1'b1;
        #1;
        checks++;
        if (sensor_pedestrian !== 1'b1) begin
            errors++;
            $display("FAIL ped_before_serve got %b exp 1", sensor_pedestrian);
        end
    endtask

    task automatic test_serve();
        logic exp;
        for (int n = 1; n <= 40; n++) begin
            ped_served     = (n <= 10);
            ped_button_raw = (n <= 12);
            tick(1);
            checks++;
            if (sensor_pedestrian !== 1'b0) begin
                errors++;
                $display("FAIL serve_ignore tick=%0d got %b exp 0", n, sensor_pedestrian);
            end
        end
        for (int n = 1; n <= 12; n++) begin
            ped_button_raw = 1'b1;
            tick(1);
            exp = (n >= 11);
            checks++;
            if (sensor_pedestrian !== exp) begin
                errors++;
                $display("FAIL serve_new_press tick=%0d got %b exp %b", n, sensor_pedestrian, exp);
            end
        end
        ped_button_raw = 1'b0;
    endtask

    task automatic test_preemption();
        logic exp;
        for (int n = 1; n <= 50; n++) begin
            emerg_raw = (n <= 20);
            tick(1);
            exp = (n >= 10) && (n <= 45);
            checks++;
            if (emergency !== exp) begin
                errors++;
                $display("FAIL emerg_hold tick=%0d got %b exp %b", n, emergency, exp);
            end
            checks++;
            if (sensor_pedestrian !== 1'b1) begin
                errors++;
                $display("FAIL preempt_ped tick=%0d got %b exp 1", n, sensor_pedestrian);
            end
        end
    endtask

    task automatic test_emerg_repulse();
        logic exp;
        for (int n = 1; n <= 70; n++) begin
            emerg_raw = (n <= 20) || (n >= 33 && n <= 44);
            tick(1);
            exp = (n >= 10) && (n <= 69);
            checks++;
            if (emergency !== exp) begin
                errors++;
                $display("FAIL emerg_repulse tick=%0d got %b exp %b", n, emergency, exp);
            end
        end
        emerg_raw = 1'b0;
    endtask

    task automatic test_async_reset();
        logic exp_car;
        logic exp_ped;
        car_raw        = 1'b1;
        ped_button_raw = 1'b1;
        tick(5);
        checks++;
        if (sensor_pedestrian !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_pending got %b exp 1", sensor_pedestrian);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({sensor_car, sensor_pedestrian, emergency} !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate got %b exp 000", {sensor_car, sensor_pedestrian, emergency});
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick(1);
            exp_car = (n >= 10);
            exp_ped = (n >= 11);
            checks++;
            if ({sensor_car, sensor_pedestrian, emergency} !== {exp_car, exp_ped, 1'b0}) begin
                errors++;
                $display("FAIL areset_relatency tick=%0d got %b exp %b", n,
                         {sensor_car, sensor_pedestrian, emergency}, {exp_car, exp_ped, 1'b0});
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        clk            = 1'b0;
        rst_n          = 1'b0;
        car_raw        = 1'b0;
        ped_button_raw = 1'b0;
        emerg_raw      = 1'b0;
        ped_served     = 1'b0;

        test_reset();
        test_car_latency();
        test_ped_bounce();
        test_serve();
        test_preemption();
        test_emerg_repulse();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_request_conditioner.md
Name: tl_request_conditioner

Overview:
- Front-end stage that cleans raw field inputs (car loop, pedestrian push-button, emergency preemption) and drives the traffic light controller's sensor_car, sensor_pedestrian and emergency inputs.
- Per channel: 2-flop synchroniser, then stable-count debouncer.
- The pedestrian request is latched until the controller serves it; it is cleared by the controller's pedestrian_signal, fed back as ped_served.
- Emergency gets a minimum post-release hold so the controller cannot chatter in and out of EMERGENCY.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive cycles a synchronised input must differ from its debounced value before the debounced value flips; legal range 2..255.
- EMERG_HOLD, 16, cycles emergency stays asserted after debounced emergency input falls; legal range 0..255 (0 = no hold).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- car_raw  in  1  raw vehicle-detector level, asynchronous to clk.
- ped_button_raw  in  1  raw pedestrian push-button level, asynchronous, bouncy.
- emerg_raw  in  1  raw emergency-preemption level, asynchronous.
- ped_served  in  1  controller's pedestrian_signal (synchronous to clk, no synchroniser).
- sensor_car  out  1  debounced car presence.
- sensor_pedestrian  out  1  latched pending pedestrian request.
- emergency  out  1  debounced emergency with release hold.

Behaviour:
- Reset: rst_n low asynchronously clears all sync flops, debounced values, counters, the hold counter and the pedestrian FSM (IDLE). All outputs read 0 during reset and on the first cycle after release. A request in flight at reset is discarded.
- Synchroniser: raw -> s1 -> s2 on each edge. No reset-value bypass.
- Debouncer (identical per channel, counter width 8):
  - If s2 == deb, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1, deb <= s2 and counter <= 0.
  - Else counter increments.
  - Any single-cycle return of s2 to deb restarts the count.
- Exact latency: let E be the first edge sampling a new raw level held stable. deb changes on edge E+DEBOUNCE_CYCLES+1 (edge E+9 at default). A raw pulse shorter than DEBOUNCE_CYCLES cycles never reaches deb.
- sensor_car = deb_car (registered, no further logic).
- Pedestrian FSM (registered, 2 bits):
  - IDLE: on the edge after deb_ped rises, go PENDING. Rising edge is detected against a registered copy of deb_ped.
  - PENDING: sensor_pedestrian = 1. When ped_served == 1 at an edge, go SERVING.
  - SERVING: sensor_pedestrian = 0. Button rising edges are ignored and not queued. When ped_served == 0 at an edge, go IDLE.
  - A held button does not re-trigger; a fresh debounced rising edge is required.
  - Emergency does not clear PENDING; the request survives emergency preemption.
  - Unused encoding goes to IDLE.
- Emergency:
  - hold counter: loaded with EMERG_HOLD on the edge deb_emerg falls; decremented each edge while nonzero; cleared to 0 on the edge deb_emerg rises.
  - emergency = deb_emerg OR (hold != 0), from registered signals only.
  - Assertion latency equals the debouncer latency (edge E+DEBOUNCE_CYCLES+1).
  - Deassertion occurs after edge E'+DEBOUNCE_CYCLES+1+EMERG_HOLD, where E' is the first edge sampling raw low.
  - Re-assertion during hold keeps emergency high continuously, with no 1-cycle gap.
- Simultaneous events:
  - Button rising edge in the same cycle ped_served rises while in PENDING: go SERVING; the press is dropped.
  - deb_emerg rising and falling never coincide per channel.
- Counter arithmetic: all counters are unsigned 8-bit and never wrap. The debouncer counter is bounded by DEBOUNCE_CYCLES-1; the hold counter stops at 0.

Test Plan:
- Reset then raw car_raw 0->1 held at edge 0, default params -> sensor_car rises after edge 9 exactly, falls 9 edges after car_raw returns low.
- ped_button_raw bounce: pulses of 3,5,7 cycles high then steady high 20 cycles -> no output for the short pulses. sensor_pedestrian rises one edge after the debounced rise and stays 1 after button release until ped_served=1 is sampled.
- Serve cycle: ped_served high for 10 cycles, with 12-cycle button presses during it -> sensor_pedestrian low throughout. After ped_served falls, a new 12-cycle press re-asserts the request.
- emerg_raw high 20 cycles then low, EMERG_HOLD=16 -> emergency high from edge 9 to edge 20+9+16. Re-pulse emerg_raw 12 cycles during hold -> emergency has no gap.
- Preemption: PENDING request, then emergency asserted and released -> sensor_pedestrian stays 1 across the whole emergency interval.
- Async reset mid-debounce and in PENDING (rst_n low off-edge for 2 cycles) -> all outputs 0 immediately, the pending request is gone, and the next press takes the full latency.
